// File: rtl/diaosi_types_pkg.sv
// -----------------------------------------------------------------------------
// diaosi_types_pkg
// Shared types and constants for the diaosi memory subsystem.
//   arb_state_t   : arbiter grant state (idle, fetch granted, data granted)
//   BUS_ERR_WORD  : word returned to a requester whose RAM access timed out
//   data_req()    : combined data-side request (read or write)
// -----------------------------------------------------------------------------
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    IDLE_DIAOSI    = 2'd0,
    GRANT_I_DIAOSI = 2'd1,
    GRANT_D_DIAOSI = 2'd2
  } arb_state_t;

  localparam logic [31:0] BUS_ERR_WORD = 32'hBAD1BAD1;

  function automatic logic data_req(input logic ren, input logic wen);
    return ren | wen;
  endfunction

endpackage

// File: rtl/diaosi_arb_timer.sv
// -----------------------------------------------------------------------------
// diaosi_arb_timer
// Counts grant cycles that did not complete and flags expiry when the
// TIMEOUT-th such cycle is reached. Also intended for the cache fill controller.
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   i_clr     in  synchronous clear (wins over counting)
//   i_en      in  count this cycle
//   o_expired out high in the cycle that would be the TIMEOUT-th counted cycle
// -----------------------------------------------------------------------------
module diaosi_arb_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;
  logic             w_expired;

  // r_count holds the number of counted cycles already elapsed, so the
  // current counted cycle is the last one when r_count == TIMEOUT-1.
  assign w_expired = i_en && (r_count == CNT_W'(TIMEOUT - 1));
  assign o_expired = w_expired;

  // Cycle counter; clears on request or once expiry has been reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr || w_expired) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/diaosi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// diaosi_mem_arbiter
// Shares one single-ported RAM between the instruction-fetch and data paths.
// One requester is granted at a time; the grant is held until ram_ready,
// a dropped request, or a timeout. Data has priority; with the optional
// DIAOSI_STARVE_GUARD_EN macro, fetch is forced through after STARVE_MAX
// consecutive data completions while fetch is waiting.
// Ports:
//   CLK, nRST                      clock / async active-low reset
//   iREN, iaddr -> iwait, iload    fetch request / stall / returned word
//   dREN, dWEN, daddr, dstore      data request, address, write data
//     -> dwait, dload              data stall / returned word
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ram_ready   RAM side
//   bus_err                        one-cycle pulse on timeout
// -----------------------------------------------------------------------------
module diaosi_mem_arbiter
  import diaosi_types_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              bus_err
);

  arb_state_t r_state;
  arb_state_t w_next;

  logic w_dreq;
  logic w_i_act;
  logic w_d_act;
  logic w_expired;
  logic w_starve_hit;

  assign w_dreq  = data_req(dREN, dWEN);
  // A grant is only live while its requester still asserts its request.
  assign w_i_act = (r_state == GRANT_I_DIAOSI) && iREN;
  assign w_d_act = (r_state == GRANT_D_DIAOSI) && w_dreq;

  diaosi_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (CLK),
    .rst_n     (nRST),
    .i_clr     (w_next == IDLE_DIAOSI),
    .i_en      ((w_i_act || w_d_act) && !ram_ready),
    .o_expired (w_expired)
  );

`ifdef DIAOSI_STARVE_GUARD_EN
  localparam int ST_W = $clog2(STARVE_MAX + 1);
  logic [ST_W-1:0] r_starve;

  // Consecutive data completions while fetch waits; any fetch grant or an
  // idle fetch side restarts the count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve <= '0;
    end else if (!iREN || ((r_state == IDLE_DIAOSI) && (w_next == GRANT_I_DIAOSI))) begin
      r_starve <= '0;
    end else if (w_d_act && ram_ready && (r_starve != ST_W'(STARVE_MAX))) begin
      r_starve <= r_starve + ST_W'(1);
    end else begin
      r_starve <= r_starve;
    end
  end

  assign w_starve_hit = (r_starve == ST_W'(STARVE_MAX));
`else
  // Strict data priority; STARVE_MAX is kept referenced so both builds
  // share the same parameter list without an unused-parameter hazard.
  assign w_starve_hit = 1'b0 & (STARVE_MAX > 0);
`endif

  // Grant state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE_DIAOSI;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection and combinational RAM/requester outputs.
  always_comb begin
    w_next   = r_state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = w_dreq;
    iload    = '0;
    dload    = '0;
    bus_err  = w_expired;
    case (r_state)
      IDLE_DIAOSI: begin
        if (w_starve_hit && iREN) begin
          w_next = GRANT_I_DIAOSI;
        end else if (w_dreq) begin
          w_next = GRANT_D_DIAOSI;
        end else if (iREN) begin
          w_next = GRANT_I_DIAOSI;
        end else begin
          w_next = IDLE_DIAOSI;
        end
      end
      GRANT_I_DIAOSI: begin
        if (w_i_act) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_ready) begin
            iwait  = 1'b0;
            iload  = ramload;
            w_next = IDLE_DIAOSI;
          end else if (w_expired) begin
            iwait  = 1'b0;
            iload  = DATA_W'(BUS_ERR_WORD);
            w_next = IDLE_DIAOSI;
          end else begin
            w_next = GRANT_I_DIAOSI;
          end
        end else begin
          w_next = IDLE_DIAOSI;
        end
      end
      GRANT_D_DIAOSI: begin
        if (w_d_act) begin
          // A simultaneous read and write is issued as the write alone.
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_ready) begin
            dwait  = 1'b0;
            dload  = ramload;
            w_next = IDLE_DIAOSI;
          end else if (w_expired) begin
            dwait  = 1'b0;
            dload  = DATA_W'(BUS_ERR_WORD);
            w_next = IDLE_DIAOSI;
          end else begin
            w_next = GRANT_D_DIAOSI;
          end
        end else begin
          w_next = IDLE_DIAOSI;
        end
      end
      default: begin
        w_next = IDLE_DIAOSI;
      end
    endcase
  end

endmodule

// File: tb/tb_diaosi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_diaosi_mem_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model that tracks which requester owns the RAM and
// how long it has waited.
// -----------------------------------------------------------------------------
module tb_diaosi_mem_arbiter;
  import diaosi_types_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam int SM = 4;
`ifdef DIAOSI_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload = '0;
  logic          ram_ready = 1'b0;
  logic          bus_err;

  always #5 CLK = ~CLK;

  diaosi_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_MAX(SM)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .bus_err(bus_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_buserr = 0;
  int n_igrant = 0;

  // Model: owner 0 = nobody, 1 = fetch, 2 = data; wait = uncompleted grant cycles.
  int m_owner = 0;
  int m_wait = 0;
  int m_starve = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] ds,
                     input logic rdy, input logic [31:0] rl);
    logic dq, act, tmo;
    logic e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_addr, e_st, e_il, e_dl, word;
    int nxt;
    @(negedge CLK);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ram_ready = rdy; ramload = rl;
    #1;
    dq = dr | dw;
    e_iw = ir; e_dw = dq; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = 32'h0; e_st = 32'h0; e_il = 32'h0; e_dl = 32'h0;
    tmo = 1'b0;
    act = (m_owner == 1 && ir) || (m_owner == 2 && dq);
    nxt = m_owner;
    if (m_owner == 0) begin
      if (GUARD && m_starve == SM && ir) nxt = 1;
      else if (dq) nxt = 2;
      else if (ir) nxt = 1;
      else nxt = 0;
    end else if (!act) begin
      nxt = 0;
    end else begin
      tmo = !rdy && (m_wait + 1 == TO);
      if (m_owner == 1) begin
        e_ren = 1'b1; e_addr = ia;
      end else begin
        e_wen = dw; e_ren = dr && !dw; e_addr = da; e_st = ds;
      end
      if (rdy || tmo) begin
        word = rdy ? rl : 32'hBAD1BAD1;
        if (m_owner == 1) begin e_iw = 1'b0; e_il = word; end
        else begin e_dw = 1'b0; e_dl = word; end
        nxt = 0;
      end
    end
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_st);
    chk("bus_err", bus_err, tmo);
    if (bus_err) n_buserr++;
    if (ramREN && m_owner == 1) n_igrant++;
    if (!ir || (m_owner == 0 && nxt == 1)) m_starve = 0;
    else if (m_owner == 2 && act && rdy) m_starve++;
    if (nxt == 0) m_wait = 0;
    else if (act && !rdy) m_wait++;
    m_owner = nxt;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, $urandom);
  endtask

  initial begin
    logic ir, dr, dw, rdy;
    logic [31:0] ia, da, ds;

    // Reset state: RAM side quiet, waits follow requests.
    #2;
    iREN = 1'b1; dREN = 1'b1; iaddr = $urandom; daddr = $urandom;
    ram_ready = 1'b1; ramload = $urandom;
    #1;
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk("rst_iwait", iwait, 1'b1);
    chk("rst_dwait", dwait, 1'b1);
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // Fetch only, RAM ready on the second grant cycle.
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2408000A);
    idle_cyc();

    // Simultaneous fetch and data write: data first, idle gap, then fetch.
    n_igrant = 0;
    cyc(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h55, 1'b0, 32'h0);
    cyc(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h55, 1'b0, 32'h0);
    cyc(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h55, 1'b1, 32'h0);
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h80, 32'h55, 1'b1, 32'h1234);
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE0001);
    chk("simul_fetch_granted", n_igrant, 1);
    idle_cyc();

    // Timeout on a data read with the RAM never ready.
    n_buserr = 0;
    for (int k = 0; k < 17; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, $urandom);
    chk("timeout_pulses", n_buserr, 1);
    idle_cyc();
    idle_cyc();

    // Abort: fetch dropped after one grant cycle.
    n_buserr = 0;
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idle_cyc();
    chk("abort_no_bus_err", n_buserr, 0);

    // Reset between edges while data write is granted.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 32'h99, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 32'h99, 1'b0, 32'h0);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_ramWEN", ramWEN, 1'b0);
    chk("midrst_ramaddr", ramaddr, 32'h0);
    chk("midrst_dwait", dwait, 1'b1);
    m_owner = 0; m_wait = 0; m_starve = 0;
    dWEN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'hB0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'hB0, 32'h0, 1'b1, 32'h0BADF00D);
    idle_cyc();

    // Data held continuously with fetch pending.
    n_igrant = 0;
    for (int k = 0; k < 30; k++) cyc(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, $urandom);
    if (GUARD) chk("starve_fetch_granted", n_igrant, 3);
    else chk("strict_fetch_never", n_igrant, 0);
    idle_cyc();
    idle_cyc();

    // Randomized traffic with sticky requests.
    ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = 32'h0; da = 32'h0; ds = 32'h0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        ir = $urandom_range(0, 1) == 1;
        dr = $urandom_range(0, 2) == 0;
        dw = $urandom_range(0, 2) == 0;
        ia = $urandom; da = $urandom; ds = $urandom;
      end
      rdy = $urandom_range(0, 5) == 0;
      cyc(ir, ia, dr, dw, da, ds, rdy, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/diaosi_mem_arbiter.md
Name: diaosi_mem_arbiter

Overview:
- Sequencing arbiter that shares the single-ported RAM between the instruction-fetch path and the data-memory path of the processor.
- Grants one requester at a time and holds the grant until the RAM signals completion or a timeout expires.
- Returns wait/load signals to each requester; sits between the fetch/memory stages and the RAM model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max RAM cycles per grant before forced abort; counter width = $clog2(TIMEOUT+1)
- STARVE_MAX, 4, consecutive data grants allowed while fetch pending (only with STARVE_GUARD_EN)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  fetch stall
- iload  out  DATA_W  fetched word
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  data stall
- dload  out  DATA_W  read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ram_ready  in  1  RAM access complete this cycle
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - nRST is asynchronous, active-low.
  - Reset forces state IDLE, timeout counter 0, starve counter 0.
- Outputs during reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, bus_err=0, iload=0, dload=0.
  - iwait = iREN.
  - dwait = dREN|dWEN.
- State register: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - If dREN|dWEN, go to GRANT_D; else if iREN, go to GRANT_I.
  - Data has fixed priority.
  - RAM enables are 0 in IDLE.
- GRANT_x:
  - ramaddr, ramREN/ramWEN and ramstore are driven combinationally from the granted requester.
  - For data, dWEN has precedence: dREN&dWEN is issued as a write only.
- Completion:
  - In the cycle ram_ready=1 while granted, the granted wait drops to 0 for exactly that cycle.
  - The matching load (iload/dload) equals ramload combinationally.
  - Next state is IDLE.
- Ungranted requester: its wait stays 1 whenever its request is asserted.
  - Any wait is 0 whenever its request is deasserted.
- Minimum latency: 2 cycles from request to wait=0 (IDLE cycle plus one RAM cycle with ram_ready=1).
- Back-to-back: after completion, one IDLE cycle always precedes the next grant.
- Request dropped while granted:
  - Abort; RAM enables go 0 in that same cycle (combinational).
  - Return to IDLE next edge; no bus_err.
- Timeout:
  - Counter increments each GRANT cycle without ram_ready.
  - On reaching TIMEOUT: bus_err=1 for one cycle, granted wait=0, load=32'hBAD1BAD1, go IDLE, counter cleared.
- Counter clears on every entry to IDLE.
- Reset mid-grant: immediate return to IDLE; RAM enables drop asynchronously.
- ram_ready while in IDLE is ignored.

Optional Feature:
- Macro: DIAOSI_STARVE_GUARD_EN.
- Defined:
  - A starve counter increments on each completed data grant while iREN=1, and clears on any instruction grant or when iREN=0.
  - When the counter equals STARVE_MAX, IDLE grants fetch even if data is pending.
- Undefined: strict data priority; starve counter and parameter unused.

Decomposition:
- Add to diaosi_types_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE_DIAOSI, GRANT_I_DIAOSI, GRANT_D_DIAOSI}.
  - Constant BUS_ERR_WORD = 32'hBAD1BAD1.
- One natural sub-module: diaosi_arb_timer.
  - Timeout counter with clear, enable and expired outputs.
  - Reused later for the cache fill controller.

Test Plan:
- Fetch only: iREN=1, iaddr=0x40, RAM ready after 2 cycles with ramload=0x2408000A -> iwait=1 for 2 cycles, then iwait=0 for 1 cycle with iload=0x2408000A; ramREN=1 during grant.
- Simultaneous: iREN=1, dWEN=1, daddr=0x80, dstore=0x55 -> first grant D (ramWEN=1, ramaddr=0x80, ramstore=0x55), iwait=1 throughout; after dwait drops, IDLE cycle, then GRANT_I.
- Timeout, TIMEOUT=15: dREN=1, ram_ready held 0 -> bus_err pulses exactly once at the 15th grant cycle, dwait=0, dload=0xBAD1BAD1, back to IDLE.
- Abort: grant I, drop iREN after 1 cycle -> ramREN=0 same cycle, IDLE next edge, bus_err stays 0.
- Reset mid-grant: assert nRST=0 between clock edges during GRANT_D -> ramWEN=0 immediately; state IDLE after release; first request served normally.
- With DIAOSI_STARVE_GUARD_EN, STARVE_MAX=4: dREN held high continuously, iREN=1 -> after 4 data completions the 5th grant is GRANT_I; without the macro, fetch never granted.
